// File: rtl/eu_icon_tx_sched_pkg.sv
// Shared types for the EU interconnect transmit path: TX queue entry layout,
// TX scheduler state encoding and the widths they are built from.
package exec_unit_dtypes;

   localparam int ICON_EU_IDX_W = 2;
   localparam int ICON_DATA_W   = 16;

   // One queued ALU result waiting for the interconnect
   typedef struct packed {
      logic [ICON_EU_IDX_W-1:0] eu_idx;
      logic                     opx;
      logic [ICON_DATA_W-1:0]   data;
   } type_icon_TXQentry;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_REQ,
      TX_SEND,
      TX_RELEASE
   } tx_state_e;

endpackage

// File: rtl/eu_icon_tx_sched_ram_queue.sv
// Register-based FIFO. Head entry is visible on rdata_o whenever non-empty;
// push is refused when full even if a pop happens the same cycle.
module ram_queue #(
   parameter int DATA_WIDTH = 8,
   parameter int LOG2_SIZE  = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic [LOG2_SIZE:0]    count_o,
   output logic                  full_o
);

   localparam int DEPTH = 1 << LOG2_SIZE;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [LOG2_SIZE-1:0]  wr_ptr;
   logic [LOG2_SIZE-1:0]  rd_ptr;
   logic                  push_ok;
   logic                  pop_ok;

   assign full_o  = (count_o == (LOG2_SIZE+1)'(DEPTH));
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && (count_o != '0);
   assign rdata_o = mem[rd_ptr];

   // Pointers wrap naturally modulo DEPTH; occupancy tracks push/pop balance
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_o <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_o <= count_o + 1'b1;
            2'b01:   count_o <= count_o - 1'b1;
            default: count_o <= count_o;
         endcase
      end
   end

   // Storage needs no reset: contents are only observed through valid entries
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata_i;
   end

endmodule

// File: rtl/eu_icon_tx_sched.sv
// Transmit scheduler for one execution unit: queues ALU results, requests the
// shared interconnect channel and streams packets while granted, bounded by a
// per-grant burst limit and a no-ready timeout so one EU cannot hog the bus.
module eu_icon_tx_sched
   import exec_unit_dtypes::*;
#(
   parameter int EU_IDX     = 0,
   parameter int EU_IDX_W   = 2,
   parameter int DATA_W     = 16,
   parameter int LOG2_DEPTH = 2,
   parameter int MAX_BURST  = 4,
   parameter int MAX_WAIT   = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [EU_IDX_W-1:0]   in_eu_idx_i,
   input  logic                  in_opx_i,
   input  logic [DATA_W-1:0]     in_data_i,
   output logic                  bus_req_o,
   input  logic                  bus_gnt_i,
   output logic                  tx_valid_o,
   output logic [EU_IDX_W-1:0]   tx_addr_o,
   output logic                  tx_opx_o,
   output logic [DATA_W-1:0]     tx_data_o,
   input  logic                  tx_ready_i,
   output logic [LOG2_DEPTH:0]   count_o
);

   localparam int BURST_W = $clog2(MAX_BURST + 1);
   localparam int WAIT_W  = $clog2(MAX_WAIT);
   localparam int CNT_W   = LOG2_DEPTH + 1;

   // The queue entry layout is fixed in the package; catch mismatched builds
   if (EU_IDX_W != ICON_EU_IDX_W || DATA_W != ICON_DATA_W) begin : g_bad_width
      $error("eu_icon_tx_sched: widths disagree with exec_unit_dtypes");
   end
   if (EU_IDX < 0 || EU_IDX >= (1 << EU_IDX_W)) begin : g_bad_idx
      $error("eu_icon_tx_sched: EU_IDX out of range");
   end

   tx_state_e          state, state_nxt;
   logic [BURST_W-1:0] burst_cnt;
   logic [WAIT_W-1:0]  wait_cnt;
   type_icon_TXQentry  wr_entry, head;
   logic               full;
   logic               push, pop;
   logic               last_entry;

   assign wr_entry.eu_idx = in_eu_idx_i;
   assign wr_entry.opx    = in_opx_i;
   assign wr_entry.data   = in_data_i;

   assign in_ready_o = !full;
   assign push       = in_valid_i && in_ready_o;
   assign pop        = tx_valid_o && tx_ready_i;
   // This pop empties the queue unless a new result lands the same cycle
   assign last_entry = (count_o == CNT_W'(1)) && !push;

   ram_queue #(
      .DATA_WIDTH ($bits(type_icon_TXQentry)),
      .LOG2_SIZE  (LOG2_DEPTH)
   ) u_txq (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (push),
      .wdata_i (wr_entry),
      .pop_i   (pop),
      .rdata_o (head),
      .count_o (count_o),
      .full_o  (full)
   );

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= TX_IDLE;
      else          state <= state_nxt;
   end

   // Next-state: request while work is queued, release on burst/empty/timeout
   always_comb begin
      state_nxt = state;
      case (state)
         TX_IDLE:    if (count_o != '0) state_nxt = TX_REQ;
         TX_REQ:     if (bus_gnt_i) state_nxt = TX_SEND;
         TX_SEND: begin
            if (!bus_gnt_i)
               state_nxt = TX_REQ;
            else if (pop) begin
               if (burst_cnt == BURST_W'(MAX_BURST - 1) || last_entry)
                  state_nxt = TX_RELEASE;
            end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1))
               state_nxt = TX_RELEASE;
         end
         TX_RELEASE: state_nxt = TX_IDLE;
         default:    state_nxt = TX_IDLE;
      endcase
   end

   // Outputs: request held through REQ/SEND, packet fields zeroed when idle
   always_comb begin
      bus_req_o  = 1'b0;
      tx_valid_o = 1'b0;
      case (state)
         TX_REQ:  bus_req_o = 1'b1;
         TX_SEND: begin
            bus_req_o  = 1'b1;
            tx_valid_o = bus_gnt_i && (count_o != '0);
         end
         default: ;
      endcase
      tx_addr_o = tx_valid_o ? head.eu_idx : '0;
      tx_opx_o  = tx_valid_o ? head.opx    : 1'b0;
      tx_data_o = tx_valid_o ? head.data   : '0;
   end

   // Burst and wait counters only run in SEND; everything else clears them
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         burst_cnt <= '0;
         wait_cnt  <= '0;
      end else if (state == TX_SEND && bus_gnt_i) begin
         if (pop) begin
            burst_cnt <= burst_cnt + 1'b1;
            wait_cnt  <= '0;
         end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
            wait_cnt  <= '0;
         end else begin
            wait_cnt  <= wait_cnt + 1'b1;
         end
      end else begin
         burst_cnt <= '0;
         wait_cnt  <= '0;
      end
   end

endmodule

// File: tb/tb_eu_icon_tx_sched.sv
// Bench for eu_icon_tx_sched: cycle table for the single-packet path,
// scripted corner sequences, and a queue model that checks every delivered
// packet, occupancy and back-pressure each cycle.
module tb_eu_icon_tx_sched;

   localparam int EW = 2;
   localparam int DW = 16;
   localparam int QW = EW + 1 + DW;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          in_valid_i;
   logic          in_ready_o;
   logic [EW-1:0] in_eu_idx_i;
   logic          in_opx_i;
   logic [DW-1:0] in_data_i;
   logic          bus_req_o;
   logic          bus_gnt_i;
   logic          tx_valid_o;
   logic [EW-1:0] tx_addr_o;
   logic          tx_opx_o;
   logic [DW-1:0] tx_data_o;
   logic          tx_ready_i;
   logic [2:0]    count_o;

   int tests = 0;
   int fails = 0;
   int n_pop = 0;
   logic [QW-1:0] sb [$];

   eu_icon_tx_sched #(
      .EU_IDX(0), .EU_IDX_W(EW), .DATA_W(DW),
      .LOG2_DEPTH(2), .MAX_BURST(4), .MAX_WAIT(8)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .in_eu_idx_i(in_eu_idx_i), .in_opx_i(in_opx_i), .in_data_i(in_data_i),
      .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i),
      .tx_valid_o(tx_valid_o), .tx_addr_o(tx_addr_o), .tx_opx_o(tx_opx_o),
      .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i), .count_o(count_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Drive point just after the edge, sample point on the falling edge
   task automatic nxt(); @(posedge clk); #1; endtask
   task automatic smp(); @(negedge clk); endtask

   task automatic drive(input logic v, input logic [EW-1:0] eu, input logic opx, input logic [DW-1:0] d);
      in_valid_i = v; in_eu_idx_i = eu; in_opx_i = opx; in_data_i = d;
   endtask

   task automatic wait_valid(input string nm);
      int n = 0;
      while (!tx_valid_o && n < 20) begin nxt(); smp(); n++; end
      chk(nm, tx_valid_o, 1);
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while (sb.size() != 0 && n < 60) begin nxt(); smp(); n++; end
      chk(nm, sb.size(), 0);
   endtask

   // Queue model: occupancy, back-pressure, idle fields and delivery order
   int sz;
   logic [QW-1:0] exp_pkt;
   always @(negedge clk) begin
      if (!reset_n) sb.delete();
      else begin
         sz = sb.size();
         chk("count", count_o, sz);
         chk("in_ready", in_ready_o, sz < 4);
         if (!tx_valid_o) chk("idle_fields", {tx_addr_o, tx_opx_o, tx_data_o}, 0);
         if (tx_valid_o && tx_ready_i) begin
            chk("pop_has_entry", sz != 0, 1);
            if (sz != 0) begin
               exp_pkt = sb.pop_front();
               chk("pkt", {tx_addr_o, tx_opx_o, tx_data_o}, exp_pkt);
               n_pop++;
            end
         end
         if (in_valid_i && sz < 4) sb.push_back({in_eu_idx_i, in_opx_i, in_data_i});
      end
   end

   typedef struct {
      logic          v;
      logic [EW-1:0] eu;
      logic          opx;
      logic [DW-1:0] d;
      logic          gnt;
      logic          rdy;
      logic          e_req;
      logic          e_val;
      logic [2:0]    e_cnt;
      logic [EW-1:0] e_addr;
      logic [DW-1:0] e_data;
   } vec_t;
   vec_t vt [6];

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int base;
      int seen;
      logic got5;

      reset_n = 1'b0; bus_gnt_i = 1'b0; tx_ready_i = 1'b0;
      drive(1'b0, '0, 1'b0, '0);
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      smp();
      chk("rst_req", bus_req_o, 0);
      chk("rst_valid", tx_valid_o, 0);
      chk("rst_count", count_o, 0);
      chk("rst_ready", in_ready_o, 1);

      // Single packet, grant and ready held high: valid in cycle 3
      vt[0] = '{1, 2'd2, 1, 16'hBEEF, 1, 1, 0, 0, 3'd0, 2'd0, 16'h0};
      vt[1] = '{0, 2'd0, 0, 16'h0,    1, 1, 0, 0, 3'd1, 2'd0, 16'h0};
      vt[2] = '{0, 2'd0, 0, 16'h0,    1, 1, 1, 0, 3'd1, 2'd0, 16'h0};
      vt[3] = '{0, 2'd0, 0, 16'h0,    1, 1, 1, 1, 3'd1, 2'd2, 16'hBEEF};
      vt[4] = '{0, 2'd0, 0, 16'h0,    1, 1, 0, 0, 3'd0, 2'd0, 16'h0};
      vt[5] = '{0, 2'd0, 0, 16'h0,    1, 1, 0, 0, 3'd0, 2'd0, 16'h0};
      for (int i = 0; i < 6; i++) begin
         nxt();
         drive(vt[i].v, vt[i].eu, vt[i].opx, vt[i].d);
         bus_gnt_i = vt[i].gnt; tx_ready_i = vt[i].rdy;
         smp();
         chk($sformatf("vec%0d_req", i), bus_req_o, vt[i].e_req);
         chk($sformatf("vec%0d_valid", i), tx_valid_o, vt[i].e_val);
         chk($sformatf("vec%0d_count", i), count_o, vt[i].e_cnt);
         chk($sformatf("vec%0d_addr", i), tx_addr_o, vt[i].e_addr);
         chk($sformatf("vec%0d_data", i), tx_data_o, vt[i].e_data);
      end

      // Fill with grant low, then burst of 4 and release at the burst limit
      bus_gnt_i = 1'b0; tx_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         nxt(); drive(1'b1, EW'(i), i[0], 16'hA000 + 16'(i)); smp();
      end
      nxt(); drive(1'b1, 2'd3, 1'b1, 16'hA004); smp();
      chk("full_ready", in_ready_o, 0);
      chk("full_count", count_o, 4);
      repeat (2) begin nxt(); smp(); chk("full_wait_req", bus_req_o, 1); end
      nxt(); bus_gnt_i = 1'b1; smp();
      got5 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         nxt();
         if (got5) in_valid_i = 1'b0;
         smp();
         chk($sformatf("burst%0d_valid", i), tx_valid_o, 1);
         if (in_valid_i && in_ready_o) got5 = 1'b1;
      end
      nxt(); in_valid_i = 1'b0; smp();
      chk("burst_release_req", bus_req_o, 0);
      chk("burst_left", count_o, 1);
      chk("fifth_pushed", got5, 1);
      drain("burst_drain");
      repeat (3) begin nxt(); smp(); end

      // Timeout: 8 SEND cycles without ready, head retained and resent
      tx_ready_i = 1'b0;
      nxt(); drive(1'b1, 2'd3, 1'b0, 16'h7777); smp();
      nxt(); in_valid_i = 1'b0; smp();
      wait_valid("to_valid");
      k = 0;
      while (tx_valid_o && k < 20) begin k++; nxt(); smp(); end
      chk("to_len", k, 8);
      chk("to_release_req", bus_req_o, 0);
      chk("to_kept", count_o, 1);
      nxt(); tx_ready_i = 1'b1; smp();
      base = n_pop;
      drain("to_drain");
      chk("to_delivered", n_pop - base, 1);
      repeat (3) begin nxt(); smp(); end

      // Grant loss mid-SEND: valid drops at once, back to REQ, nothing lost
      tx_ready_i = 1'b0;
      nxt(); drive(1'b1, 2'd1, 1'b1, 16'h1111); smp();
      nxt(); drive(1'b1, 2'd2, 1'b0, 16'h2222); smp();
      nxt(); in_valid_i = 1'b0; smp();
      wait_valid("gl_valid");
      nxt(); bus_gnt_i = 1'b0; smp();
      chk("gl_drop_valid", tx_valid_o, 0);
      nxt(); smp();
      chk("gl_req", bus_req_o, 1);
      chk("gl_count", count_o, 2);
      nxt(); bus_gnt_i = 1'b1; tx_ready_i = 1'b1; smp();
      drain("gl_drain");
      repeat (3) begin nxt(); smp(); end

      // Stream 12 packets with continuous pushes; pointers wrap several times
      base = n_pop;
      k = 0; seen = 0;
      while (k < 12 && seen < 200) begin
         nxt(); drive(1'b1, EW'(k), k[1], 16'hC000 + 16'(k)); smp();
         if (in_ready_o) k++;
         seen++;
      end
      nxt(); in_valid_i = 1'b0; smp();
      drain("stream_drain");
      chk("stream_delivered", n_pop - base, 12);
      repeat (3) begin nxt(); smp(); end

      // Reset in the middle of a SEND with 3 entries queued
      bus_gnt_i = 1'b0; tx_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         nxt(); drive(1'b1, EW'(i), 1'b1, 16'hD000 + 16'(i)); smp();
      end
      nxt(); in_valid_i = 1'b0; bus_gnt_i = 1'b1; smp();
      wait_valid("rm_valid");
      nxt(); reset_n = 1'b0; #1;
      chk("rm_valid0", tx_valid_o, 0);
      chk("rm_req0", bus_req_o, 0);
      chk("rm_data0", tx_data_o, 0);
      chk("rm_count0", count_o, 0);
      nxt(); smp();
      nxt(); reset_n = 1'b1; tx_ready_i = 1'b1; smp();
      chk("rm_count_after", count_o, 0);
      chk("rm_ready_after", in_ready_o, 1);
      seen = 0;
      repeat (6) begin nxt(); smp(); seen += int'(tx_valid_o); end
      chk("rm_no_tx", seen, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
